ncm_nlfsr_stream: RTL and testbench

Parametrised keystream generator built from two cross-coupled nonlinear feedback shift registers (NLFSRs), A and B. Tap masks, AND-term positions, warm-up length and output word width are all parameters. After a seed load it discards a programmable number of warm-up steps, then packs one keystream bit per step into OUT_W-bit words and delivers them on a valid/ready stream port with backpressure. It sits between the seed/config register file and the NCM data scrambler.

---
 rtl/ncm_nlfsr_stream.sv | 120 ++++++++++++
 tb/tb_ncm_nlfsr_stream.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncm_nlfsr_stream.sv
// Keystream generator: two cross-coupled NLFSRs, WARMUP discarded steps after a load, then
// one bit per step packed LSB-first into OUT_W-bit words on a valid/ready port that stalls rather than drops.
module ncm_nlfsr_stream #(
  parameter int               W_A    = 29,
  parameter int               W_B    = 27,
  parameter logic [W_A-1:0]   TAPS_A = 29'h08C91869,
  parameter logic [W_B-1:0]   TAPS_B = 27'h02A4D17,
  parameter int               AND_A1 = 28,
  parameter int               AND_A0 = 20,
  parameter int               AND_B1 = 10,
  parameter int               AND_B0 = 6,
  parameter int               WARMUP = 112,
  parameter int               OUT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W_A+W_B-1:0]   i_seed,
  input  logic                 i_load,
  input  logic                 i_halt,
  output logic [OUT_W-1:0]     o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [W_A+W_B-1:0]   o_state,
  output logic                 o_warm,
  output logic                 o_seed_err
);

  localparam int WC_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int PC_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [WC_W-1:0] WARM_LAST = WC_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [PC_W-1:0] PACK_LAST = PC_W'(OUT_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WARM = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [W_A-1:0]   reg_a;
  logic [W_B-1:0]   reg_b;
  logic [1:0]       state;
  logic [WC_W-1:0]  warm_cnt;
  logic [PC_W-1:0]  pack_cnt;
  logic [OUT_W-1:0] pack;

  logic             fb_a;
  logic             fb_b;
  logic             ks_bit;
  logic             word_done;
  logic             stall;
  logic             step;
  logic [OUT_W-1:0] word_next;

  always_comb begin
    fb_a      = (reg_a[AND_A1] & reg_a[AND_A0]) ^ (^(reg_a & TAPS_A)) ^ reg_b[0];
    fb_b      = (reg_b[AND_B1] & reg_b[AND_B0]) ^ (^(reg_b & TAPS_B)) ^ reg_a[0];
    ks_bit    = reg_a[0] ^ reg_b[0];
    word_done = (pack_cnt == PACK_LAST);
    // Only the word-completing step can collide with an unaccepted word, so only it stalls.
    stall     = (state == S_RUN) && word_done && o_valid && !i_ready;
    step      = (state != S_IDLE) && !i_halt && !stall;
    word_next = pack;
    word_next[pack_cnt] = ks_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a      <= '0;
      reg_b      <= '0;
      state      <= S_IDLE;
      warm_cnt   <= '0;
      pack_cnt   <= '0;
      pack       <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_seed_err <= 1'b0;
    end else if (i_load) begin
      warm_cnt <= '0;
      pack_cnt <= '0;
      o_valid  <= 1'b0;
      if (i_seed != '0) begin
        {reg_a, reg_b} <= i_seed;
        o_seed_err     <= 1'b0;
        state          <= (WARMUP == 0) ? S_RUN : S_WARM;
      end else begin
        reg_a      <= '0;
        reg_b      <= '0;
        o_seed_err <= 1'b1;
        state      <= S_IDLE;
      end
    end else begin
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (step) begin
        reg_a <= {fb_a, reg_a[W_A-1:1]};
        reg_b <= {fb_b, reg_b[W_B-1:1]};
        if (state == S_WARM) begin
          if (warm_cnt == WARM_LAST) begin
            state <= S_RUN;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end else begin
          pack <= word_next;
          // A completing word overrides the clear from a same-cycle transfer.
          if (word_done) begin
            o_data   <= word_next;
            o_valid  <= 1'b1;
            pack_cnt <= '0;
          end else begin
            pack_cnt <= pack_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign o_state = {reg_a, reg_b};
  assign o_warm  = (state == S_WARM);

endmodule

// File: tb/tb_ncm_nlfsr_stream.sv
// Bench for ncm_nlfsr_stream: a default instance (WARMUP=112) and a WARMUP=0 instance,
// checked against a reference NLFSR model through per-instance word scoreboards.
module tb_ncm_nlfsr_stream;

  localparam logic [28:0] TA = 29'h08C91869;
  localparam logic [26:0] TB = 27'h02A4D17;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [55:0] d_seed, z_seed, d_state, z_state;
  logic        d_load, d_halt, d_ready, d_valid, d_warm, d_err;
  logic        z_load, z_halt, z_ready, z_valid, z_warm, z_err;
  logic [7:0]  d_data, z_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] q_d[$];
  logic [7:0] q_z[$];

  ncm_nlfsr_stream dut (
    .clk(clk), .rst(rst), .i_seed(d_seed), .i_load(d_load), .i_halt(d_halt),
    .o_data(d_data), .o_valid(d_valid), .i_ready(d_ready), .o_state(d_state),
    .o_warm(d_warm), .o_seed_err(d_err)
  );

  ncm_nlfsr_stream #(.WARMUP(0)) dut0 (
    .clk(clk), .rst(rst), .i_seed(z_seed), .i_load(z_load), .i_halt(z_halt),
    .o_data(z_data), .o_valid(z_valid), .i_ready(z_ready), .o_state(z_state),
    .o_warm(z_warm), .o_seed_err(z_err)
  );

  function automatic logic [55:0] mstep(input logic [55:0] s, output logic ks);
    logic [28:0] a;
    logic [26:0] b;
    logic        fa, fb;
    a  = s[55:27];
    b  = s[26:0];
    ks = a[0] ^ b[0];
    fa = (a[28] & a[20]) ^ (^(a & TA)) ^ b[0];
    fb = (b[10] & b[6]) ^ (^(b & TB)) ^ a[0];
    return {fa, a[28:1], fb, b[26:1]};
  endfunction

  task automatic push_words(input logic [55:0] seed, input int skip, input int n, input bit to_z);
    logic [55:0] s;
    logic        ks;
    logic [7:0]  w;
    s = seed;
    for (int i = 0; i < skip; i++) s = mstep(s, ks);
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < 8; k++) begin
        s = mstep(s, ks);
        w[k] = ks;
      end
      if (to_z) q_z.push_back(w);
      else      q_d.push_back(w);
    end
  endtask

  // Entered and left at #1 after a rising edge; the load takes effect on the next edge.
  task automatic do_load(input bit to_z, input logic [55:0] s);
    @(posedge clk);
    #1;
    if (to_z) begin z_seed = s; z_load = 1'b1; end
    else      begin d_seed = s; d_load = 1'b1; end
    @(posedge clk);
    #1;
    z_load = 1'b0;
    d_load = 1'b0;
  endtask

  // Scoreboards and hold-stability monitors, sampled on the falling edge.
  logic       d_stall = 1'b0, z_stall = 1'b0;
  logic [7:0] d_hold, z_hold, d_exp, z_exp;

  always @(negedge clk) begin
    if (d_valid && d_ready && !rst) begin
      checks++;
      if (q_d.size() == 0) begin
        errors++;
        $display("FAIL d_word: got %h with no word expected", d_data);
      end else begin
        d_exp = q_d.pop_front();
        if (d_data !== d_exp) begin
          errors++;
          $display("FAIL d_word: got %h expected %h", d_data, d_exp);
        end
      end
    end
    if (d_stall) begin
      checks++;
      if (d_valid !== 1'b1 || d_data !== d_hold) begin
        errors++;
        $display("FAIL d_hold: got valid %b data %h expected valid 1 data %h", d_valid, d_data, d_hold);
      end
    end
    d_stall = d_valid && !d_ready && !d_load && !rst;
    d_hold  = d_data;
  end

  always @(negedge clk) begin
    if (z_valid && z_ready && !rst) begin
      checks++;
      if (q_z.size() == 0) begin
        errors++;
        $display("FAIL z_word: got %h with no word expected", z_data);
      end else begin
        z_exp = q_z.pop_front();
        if (z_data !== z_exp) begin
          errors++;
          $display("FAIL z_word: got %h expected %h", z_data, z_exp);
        end
      end
    end
    if (z_stall) begin
      checks++;
      if (z_valid !== 1'b1 || z_data !== z_hold) begin
        errors++;
        $display("FAIL z_hold: got valid %b data %h expected valid 1 data %h", z_valid, z_data, z_hold);
      end
    end
    z_stall = z_valid && !z_ready && !z_load && !rst;
    z_hold  = z_data;
  end

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({d_data, d_valid, d_state, d_warm, d_err} !== '0) begin
      errors++;
      $display("FAIL reset_d: got data %h valid %b state %h warm %b err %b expected all 0",
               d_data, d_valid, d_state, d_warm, d_err);
    end
    checks++;
    if ({z_data, z_valid, z_state, z_warm, z_err} !== '0) begin
      errors++;
      $display("FAIL reset_z: got data %h valid %b state %h warm %b err %b expected all 0",
               z_data, z_valid, z_state, z_warm, z_err);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({d_state, d_valid, d_warm} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got state %h valid %b warm %b expected 0", d_state, d_valid, d_warm);
    end
  endtask

  task automatic test_zero_seed();
    int vcount;
    d_ready = 1'b1;
    do_load(1'b0, 56'h0);
    checks++;
    if ({d_err, d_state, d_valid, d_warm} !== {1'b1, 56'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL zero_seed: got err %b state %h valid %b warm %b expected err 1 state 0 valid 0 warm 0",
               d_err, d_state, d_valid, d_warm);
    end
    vcount = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (d_valid) vcount++;
    end
    checks++;
    if (vcount != 0) begin
      errors++;
      $display("FAIL zero_seed_valid: got %0d valid cycles expected 0", vcount);
    end
  endtask

  task automatic test_step();
    int n;
    z_ready = 1'b1;
    push_words(56'h1, 0, 1000, 1'b1);
    do_load(1'b1, 56'h1);
    checks++;
    if (z_state !== 56'h1) begin
      errors++;
      $display("FAIL step_load: got %h expected %h", z_state, 56'h1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (z_state !== {29'h10000000, 27'h4000000}) begin
      errors++;
      $display("FAIL step_one: got %h expected %h", z_state, {29'h10000000, 27'h4000000});
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (z_valid !== 1'b0) begin
      errors++;
      $display("FAIL step_early_valid: got %b expected 0", z_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (z_valid !== 1'b1 || z_data[1:0] !== 2'b01) begin
      errors++;
      $display("FAIL step_first_word: got valid %b bits %b expected valid 1 bits 01", z_valid, z_data[1:0]);
    end
    n = 0;
    while (q_z.size() != 0 && n < 9000) begin
      @(posedge clk);
      #1;
      n++;
    end
    z_ready = 1'b0;
    checks++;
    if (q_z.size() != 0) begin
      errors++;
      $display("FAIL step_drain: got %0d words left expected 0", q_z.size());
    end
  endtask

  task automatic test_warmup();
    int warm_n, first_v, n;
    d_ready = 1'b1;
    push_words(56'hA5A5_A5A5_A5A5_A5, 112, 4, 1'b0);
    do_load(1'b0, 56'hA5A5_A5A5_A5A5_A5);
    warm_n  = 0;
    first_v = -1;
    for (int i = 0; i < 130; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (d_warm) warm_n++;
      if (d_valid && first_v < 0) first_v = i;
    end
    checks++;
    if (warm_n != 112) begin
      errors++;
      $display("FAIL warm_len: got %0d expected 112", warm_n);
    end
    checks++;
    if (first_v != 120) begin
      errors++;
      $display("FAIL warm_first_valid: got %0d expected 120", first_v);
    end
    n = 0;
    while (q_d.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    d_ready = 1'b0;
    checks++;
    if (q_d.size() != 0) begin
      errors++;
      $display("FAIL warm_drain: got %0d words left expected 0", q_d.size());
    end
  endtask

  task automatic test_backpressure();
    int n;
    push_words(56'h3C3C_1234_5678_9A, 0, 60, 1'b1);
    do_load(1'b1, 56'h3C3C_1234_5678_9A);
    n = 0;
    while (n < 20000) begin
      z_ready = ($urandom_range(0, 9) < 3);
      z_halt  = ($urandom_range(0, 4) == 0);
      @(posedge clk);
      #1;
      n++;
      if (q_z.size() == 0) break;
    end
    z_ready = 1'b0;
    z_halt  = 1'b0;
    checks++;
    if (q_z.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got %0d words left expected 0", q_z.size());
    end
  endtask

  task automatic test_reload();
    int n;
    z_ready = 1'b1;
    push_words(56'h0123_4567_89AB_CD, 0, 2, 1'b1);
    do_load(1'b1, 56'h0123_4567_89AB_CD);
    repeat (18) @(posedge clk);
    #1;
    checks++;
    if (q_z.size() != 0) begin
      errors++;
      $display("FAIL reload_first: got %0d words left expected 0", q_z.size());
    end
    push_words(56'hFEDC_BA98_7654_32, 0, 3, 1'b1);
    do_load(1'b1, 56'hFEDC_BA98_7654_32);
    checks++;
    if (z_valid !== 1'b0 || z_state !== 56'hFEDC_BA98_7654_32) begin
      errors++;
      $display("FAIL reload_load: got valid %b state %h expected valid 0 state %h",
               z_valid, z_state, 56'hFEDC_BA98_7654_32);
    end
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (z_valid !== 1'b0) begin
      errors++;
      $display("FAIL reload_partial: got valid %b expected 0", z_valid);
    end
    n = 0;
    while (q_z.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    z_ready = 1'b0;
    checks++;
    if (q_z.size() != 0) begin
      errors++;
      $display("FAIL reload_drain: got %0d words left expected 0", q_z.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [55:0] s;
    logic [7:0]  w;
    logic        ks;
    s = 56'h00_0000_DEAD_BEEF;
    for (int k = 0; k < 8; k++) begin
      s = mstep(s, ks);
      w[k] = ks;
    end
    z_ready = 1'b0;
    do_load(1'b1, 56'h00_0000_DEAD_BEEF);
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (z_valid !== 1'b1 || z_data !== w) begin
      errors++;
      $display("FAIL mid_pending: got valid %b data %h expected valid 1 data %h", z_valid, z_data, w);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({z_data, z_valid, z_state, z_warm, z_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got data %h valid %b state %h warm %b err %b expected all 0",
               z_data, z_valid, z_state, z_warm, z_err);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    d_seed = '0; d_load = 1'b0; d_halt = 1'b0; d_ready = 1'b0;
    z_seed = '0; z_load = 1'b0; z_halt = 1'b0; z_ready = 1'b0;
    test_reset();
    test_zero_seed();
    test_step();
    test_warmup();
    test_backpressure();
    test_reload();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
